// File: rtl/hue_bbox_pkg.sv
// hue_bbox_pkg
//   Shared vision-pipeline definitions: hue scaling constants, default image
//   dimensions and the frame-tracker state encoding. No ports.
package hue_bbox_pkg;

    localparam int HUE_FIXED      = 4;
    localparam int HUE_360        = 360 * (2 ** HUE_FIXED);

    localparam int DEF_PRECISION  = 20;
    localparam int DEF_IMG_W      = 640;
    localparam int DEF_IMG_H      = 480;
    localparam int DEF_MIN_PIXELS = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    // Hue code for 360 degrees at a given number of fractional bits.
    function automatic int hue_360(input int fixed);
        return 360 * (2 ** fixed);
    endfunction

endpackage

// File: rtl/hue_window_match.sv
// hue_window_match
//   Combinational test of one hue code against an inclusive window [lo, hi].
//   When lo > hi the window wraps through 0 degrees.
// Ports:
//   i_hue    in  W  hue code under test
//   i_lo     in  W  window lower bound, inclusive
//   i_hi     in  W  window upper bound, inclusive
//   o_match  out 1  hue lies inside the window
module hue_window_match #(
    parameter int W = 20
) (
    input  logic [W-1:0] i_hue,
    input  logic [W-1:0] i_lo,
    input  logic [W-1:0] i_hi,
    output logic         o_match
);

    logic w_ge_lo;
    logic w_le_hi;

    assign w_ge_lo = (i_hue >= i_lo);
    assign w_le_hi = (i_hue <= i_hi);

    // lo == hi falls into the non-wrap branch and matches exactly one code.
    assign o_match = (i_lo <= i_hi) ? (w_ge_lo & w_le_hi) : (w_ge_lo | w_le_hi);

endmodule

// File: rtl/hue_bbox.sv
// hue_bbox
//   Per-frame colour-blob locator. Classifies each hue beat against a window
//   latched at sop and reports the bounding box and count of matching pixels
//   two cycles after eop.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/sop/eop    beat qualifiers (sop/eop qualified by in_valid)
//   hue                 pixel hue
//   hue_lo, hue_hi      window bounds, latched at sop
//   box_valid           one-cycle report pulse
//   found               pix_count >= MIN_PIXELS
//   x_min..y_max        bounding box (0 when not found)
//   pix_count           saturating match count
//   frame_err           reported frame had a length violation
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | waiting for a valid sop; other beats ignored
// ST_ACTIVE | accepting pixels of the current frame
// ST_REPORT | eop pixel is in stage 1; outputs latch on this cycle
module hue_bbox
    import hue_bbox_pkg::*;
#(
    parameter  int PRECISION  = DEF_PRECISION,
    parameter  int FIXED      = HUE_FIXED,
    parameter  int IMG_W      = DEF_IMG_W,
    parameter  int IMG_H      = DEF_IMG_H,
    parameter  int MIN_PIXELS = DEF_MIN_PIXELS,
    localparam int XW         = $clog2(IMG_W),
    localparam int YW         = $clog2(IMG_H),
    localparam int CW         = $clog2(IMG_W * IMG_H + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 in_sop,
    input  logic                 in_eop,
    input  logic [PRECISION-1:0] hue,
    input  logic [PRECISION-1:0] hue_lo,
    input  logic [PRECISION-1:0] hue_hi,
    output logic                 box_valid,
    output logic                 found,
    output logic [XW-1:0]        x_min,
    output logic [XW-1:0]        x_max,
    output logic [YW-1:0]        y_min,
    output logic [YW-1:0]        y_max,
    output logic [CW-1:0]        pix_count,
    output logic                 frame_err
);

    localparam logic [XW-1:0]        LAST_X  = XW'(IMG_W - 1);
    localparam logic [YW-1:0]        LAST_Y  = YW'(IMG_H - 1);
    localparam logic [PRECISION-1:0] HUE_LIM = PRECISION'(hue_360(FIXED));

    state_t r_state;
    state_t w_state_nxt;
    logic   w_accept;

    // -------------------------------------------------------------- FSM
    assign w_accept = in_valid & (in_sop | (r_state == ST_ACTIVE));

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // A sop in any state starts a frame; sop+eop is a complete 1-pixel frame.
    always_comb begin
        w_state_nxt = ST_IDLE;
        if (w_accept && in_eop)       w_state_nxt = ST_REPORT;
        else if (w_accept)            w_state_nxt = ST_ACTIVE;
        else if (r_state == ST_ACTIVE) w_state_nxt = ST_ACTIVE;
    end

    // ------------------------------------------------ stage 0: classify
    logic [PRECISION-1:0] r_lo, r_hi;
    logic [PRECISION-1:0] w_lo, w_hi;
    logic [XW-1:0]        r_x, w_px;
    logic [YW-1:0]        r_y, w_py;
    logic                 r_done, w_ovf, w_at_last, w_pix_err;
    logic                 w_win_match, w_match;

    // The sop pixel is judged against the bounds presented with it.
    assign w_lo = in_sop ? hue_lo : r_lo;
    assign w_hi = in_sop ? hue_hi : r_hi;

    hue_window_match #(.W(PRECISION)) u_match (
        .i_hue   (hue),
        .i_lo    (w_lo),
        .i_hi    (w_hi),
        .o_match (w_win_match)
    );

    // Codes at or above 360 degrees cannot come from the converter.
    assign w_match = w_win_match & (hue < HUE_LIM);

    // r_x/r_y is the position of the next pixel; r_done marks that the last
    // position has been consumed, so any further pixel is an overrun.
    assign w_px      = in_sop ? '0 : r_x;
    assign w_py      = in_sop ? '0 : r_y;
    assign w_ovf     = ~in_sop & r_done;
    assign w_at_last = (w_px == LAST_X) && (w_py == LAST_Y);
    assign w_pix_err = w_ovf | (in_eop & ~w_at_last);

    // --------------------------------------------- stage 1 registers
    logic          r_s1_valid, r_s1_first, r_s1_match, r_s1_err;
    logic [XW-1:0] r_s1_x;
    logic [YW-1:0] r_s1_y;

    // --------------------------------------------- stage 2 accumulate
    logic [XW-1:0] r_acc_xmn, r_acc_xmx, w_b_xmn, w_b_xmx, w_acc_xmn, w_acc_xmx;
    logic [YW-1:0] r_acc_ymn, r_acc_ymx, w_b_ymn, w_b_ymx, w_acc_ymn, w_acc_ymx;
    logic [CW-1:0] r_acc_cnt, w_b_cnt, w_acc_cnt;
    logic          r_acc_err, w_b_err, w_acc_err;
    logic          w_found;

    // The first pixel of a frame merges into a cleared accumulator instead
    // of the stored one, so a new frame never disturbs a pending report.
    always_comb begin
        if (r_s1_first) begin
            w_b_xmn = '1;
            w_b_xmx = '0;
            w_b_ymn = '1;
            w_b_ymx = '0;
            w_b_cnt = '0;
            w_b_err = 1'b0;
        end else begin
            w_b_xmn = r_acc_xmn;
            w_b_xmx = r_acc_xmx;
            w_b_ymn = r_acc_ymn;
            w_b_ymx = r_acc_ymx;
            w_b_cnt = r_acc_cnt;
            w_b_err = r_acc_err;
        end
        w_acc_xmn = w_b_xmn;
        w_acc_xmx = w_b_xmx;
        w_acc_ymn = w_b_ymn;
        w_acc_ymx = w_b_ymx;
        w_acc_cnt = w_b_cnt;
        w_acc_err = w_b_err | r_s1_err;
        if (r_s1_match) begin
            if (r_s1_x < w_b_xmn) w_acc_xmn = r_s1_x;
            if (r_s1_x > w_b_xmx) w_acc_xmx = r_s1_x;
            if (r_s1_y < w_b_ymn) w_acc_ymn = r_s1_y;
            if (r_s1_y > w_b_ymx) w_acc_ymx = r_s1_y;
            if (w_b_cnt != '1)    w_acc_cnt = w_b_cnt + CW'(1);
        end
    end

    assign w_found = (w_acc_cnt >= CW'(MIN_PIXELS));

    // ------------------------------------------------------- registers
    logic          r_box_valid, r_found, r_frame_err;
    logic [XW-1:0] r_x_min, r_x_max;
    logic [YW-1:0] r_y_min, r_y_max;
    logic [CW-1:0] r_pix_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lo        <= '0;
            r_hi        <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_done      <= 1'b0;
            r_s1_valid  <= 1'b0;
            r_s1_first  <= 1'b0;
            r_s1_match  <= 1'b0;
            r_s1_err    <= 1'b0;
            r_s1_x      <= '0;
            r_s1_y      <= '0;
            r_acc_xmn   <= '1;
            r_acc_xmx   <= '0;
            r_acc_ymn   <= '1;
            r_acc_ymx   <= '0;
            r_acc_cnt   <= '0;
            r_acc_err   <= 1'b0;
            r_box_valid <= 1'b0;
            r_found     <= 1'b0;
            r_frame_err <= 1'b0;
            r_x_min     <= '0;
            r_x_max     <= '0;
            r_y_min     <= '0;
            r_y_max     <= '0;
            r_pix_count <= '0;
        end else begin
            if (w_accept && in_sop) begin
                r_lo <= hue_lo;
                r_hi <= hue_hi;
            end

            if (w_accept) begin
                if (w_at_last) begin
                    r_x    <= w_px;
                    r_y    <= w_py;
                    r_done <= 1'b1;
                end else if (w_px == LAST_X) begin
                    r_x    <= '0;
                    r_y    <= w_py + YW'(1);
                    r_done <= 1'b0;
                end else begin
                    r_x    <= w_px + XW'(1);
                    r_y    <= w_py;
                    r_done <= 1'b0;
                end
            end

            r_s1_valid <= w_accept;
            r_s1_first <= in_sop;
            r_s1_match <= w_match;
            r_s1_err   <= w_pix_err;
            r_s1_x     <= w_px;
            r_s1_y     <= w_py;

            if (r_s1_valid) begin
                r_acc_xmn <= w_acc_xmn;
                r_acc_xmx <= w_acc_xmx;
                r_acc_ymn <= w_acc_ymn;
                r_acc_ymx <= w_acc_ymx;
                r_acc_cnt <= w_acc_cnt;
                r_acc_err <= w_acc_err;
            end

            r_box_valid <= (r_state == ST_REPORT);
            if (r_state == ST_REPORT) begin
                r_found     <= w_found;
                r_frame_err <= w_acc_err;
                r_pix_count <= w_acc_cnt;
                r_x_min     <= w_found ? w_acc_xmn : '0;
                r_x_max     <= w_found ? w_acc_xmx : '0;
                r_y_min     <= w_found ? w_acc_ymn : '0;
                r_y_max     <= w_found ? w_acc_ymx : '0;
            end
        end
    end

    assign box_valid = r_box_valid;
    assign found     = r_found;
    assign frame_err = r_frame_err;
    assign pix_count = r_pix_count;
    assign x_min     = r_x_min;
    assign x_max     = r_x_max;
    assign y_min     = r_y_min;
    assign y_max     = r_y_max;

endmodule

// File: tb/tb_hue_bbox.sv
module tb_hue_bbox;

    localparam int W    = 8;
    localparam int H    = 4;
    localparam int MINP = 2;
    localparam int HMAX = 5760;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
    logic [19:0] hue = '0, hue_lo = '0, hue_hi = '0;
    logic        box_valid, found, frame_err;
    logic [2:0]  x_min, x_max;
    logic [1:0]  y_min, y_max;
    logic [5:0]  pix_count;

    hue_bbox #(
        .PRECISION(20), .FIXED(4), .IMG_W(W), .IMG_H(H), .MIN_PIXELS(MINP)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
        .hue(hue), .hue_lo(hue_lo), .hue_hi(hue_hi),
        .box_valid(box_valid), .found(found),
        .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
        .pix_count(pix_count), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int due;
        int found;
        int xmn, xmx, ymn, ymx;
        int cnt;
        int err;
    } exp_t;

    exp_t exp_q[$];
    int   q_hue[$];
    bit   in_frame = 1'b0;
    int   m_lo, m_hi;
    int   n_pulses = 0;
    int   n_expect = 0;
    int   fr[0:63];

    function automatic bit hue_in(input int h, input int lo, input int hi);
        if (lo <= hi) return (h >= lo) && (h <= hi);
        return (h >= lo) || (h <= hi);
    endfunction

    // Whole-frame reference: pixel i sits at (i mod W, i div W); pixels past
    // the last position stay at the last position.
    function automatic exp_t model_frame(input int due);
        exp_t r;
        int n, idx, x, y;
        n = q_hue.size();
        r.due = due; r.cnt = 0;
        r.xmn = 99; r.xmx = -1; r.ymn = 99; r.ymx = -1;
        for (int i = 0; i < n; i++) begin
            idx = (i < W * H) ? i : W * H - 1;
            x = idx % W;
            y = idx / W;
            if (hue_in(q_hue[i], m_lo, m_hi)) begin
                r.cnt++;
                if (x < r.xmn) r.xmn = x;
                if (x > r.xmx) r.xmx = x;
                if (y < r.ymn) r.ymn = y;
                if (y > r.ymx) r.ymx = y;
            end
        end
        if (r.cnt > 63) r.cnt = 63;
        r.err   = (n != W * H) ? 1 : 0;
        r.found = (r.cnt >= MINP) ? 1 : 0;
        if (r.found == 0) begin
            r.xmn = 0; r.xmx = 0; r.ymn = 0; r.ymx = 0;
        end
        return r;
    endfunction

    task automatic beat(input bit v, input bit s, input bit e, input int h);
        in_valid = v; in_sop = s; in_eop = e; hue = 20'(h);
        if (v) begin
            if (s) begin
                in_frame = 1'b1;
                q_hue.delete();
                m_lo = int'(hue_lo);
                m_hi = int'(hue_hi);
            end
            if (in_frame) begin
                q_hue.push_back(h);
                if (e) begin
                    exp_q.push_back(model_frame(cyc + 2));
                    n_expect++;
                    in_frame = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 1'b0, 0);
    endtask

    // Sends fr[0..len-1] as a frame; abort_at > 0 stops before that index
    // without an eop. rnd adds invalid gap beats and mid-frame bound changes.
    task automatic send_frame(input int len, input int abort_at, input int gap, input bit rnd);
        for (int i = 0; i < len; i++) begin
            if (abort_at > 0 && i == abort_at) break;
            if (rnd && i > 0 && $urandom_range(0, 3) == 0)
                beat(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1920);
            beat(1'b1, i == 0, i == len - 1, fr[i]);
            if (rnd && $urandom_range(0, 7) == 0) begin
                hue_lo = 20'($urandom_range(0, HMAX - 1));
                hue_hi = 20'($urandom_range(0, HMAX - 1));
            end
        end
        idle(gap);
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < 64; i++) fr[i] = v;
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_box_valid"}, box_valid, 0);
        check_eq({tag, "_found"}, found, 0);
        check_eq({tag, "_x_min"}, x_min, 0);
        check_eq({tag, "_x_max"}, x_max, 0);
        check_eq({tag, "_y_min"}, y_min, 0);
        check_eq({tag, "_y_max"}, y_max, 0);
        check_eq({tag, "_pix_count"}, pix_count, 0);
        check_eq({tag, "_frame_err"}, frame_err, 0);
    endtask

    task automatic check_box(input string tag, input int f, input int x0, input int x1,
                             input int y0, input int y1, input int c, input int e);
        check_eq({tag, "_found"}, found, f);
        check_eq({tag, "_x_min"}, x_min, x0);
        check_eq({tag, "_x_max"}, x_max, x1);
        check_eq({tag, "_y_min"}, y_min, y0);
        check_eq({tag, "_y_max"}, y_max, y1);
        check_eq({tag, "_pix_count"}, pix_count, c);
        check_eq({tag, "_frame_err"}, frame_err, e);
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (box_valid === 1'b1) begin
            n_pulses++;
            if (exp_q.size() == 0) begin
                check_eq("spurious_box_valid", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("box_time", cyc, mon_e.due);
                check_eq("box_found", found, mon_e.found);
                check_eq("box_x_min", x_min, mon_e.xmn);
                check_eq("box_x_max", x_max, mon_e.xmx);
                check_eq("box_y_min", y_min, mon_e.ymn);
                check_eq("box_y_max", y_max, mon_e.ymx);
                check_eq("box_pix_count", pix_count, mon_e.cnt);
                check_eq("box_frame_err", frame_err, mon_e.err);
            end
        end
    end

    int p0, lo_r, hi_r, len, sel;

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        // Beats without sop after reset are ignored.
        beat(1'b1, 1'b0, 1'b0, 1920);
        beat(1'b1, 1'b0, 1'b1, 1920);
        beat(1'b0, 1'b1, 1'b1, 1920);
        idle(4);
        check_eq("idle_no_report", n_pulses, 0);

        // Basic box.
        hue_lo = 20'd1760; hue_hi = 20'd2080;
        fill(0); fr[10] = 1920; fr[13] = 1920; fr[27] = 1920;
        send_frame(32, 0, 4, 1'b0);
        check_box("basic", 1, 2, 5, 1, 3, 3, 0);

        // Wrap window.
        hue_lo = 20'd5600; hue_hi = 20'd160;
        fill(2000); fr[0] = 5700; fr[31] = 100;
        send_frame(32, 0, 4, 1'b0);
        check_box("wrap", 1, 0, 7, 0, 3, 2, 0);

        // Below threshold.
        hue_lo = 20'd1760; hue_hi = 20'd2080;
        fill(0); fr[20] = 1920;
        send_frame(32, 0, 4, 1'b0);
        check_box("below", 0, 0, 0, 0, 0, 1, 0);

        // Early eop at index 20.
        fill(0); fr[3] = 1920; fr[9] = 1920;
        send_frame(21, 0, 4, 1'b0);
        check_eq("early_eop_frame_err", frame_err, 1);

        // Overrun: two pixels past the last position.
        fill(0);
        send_frame(34, 0, 4, 1'b0);
        check_eq("overrun_frame_err", frame_err, 1);

        // lo == hi matches a single code.
        hue_lo = 20'd1920; hue_hi = 20'd1920;
        fill(1921); fr[5] = 1920; fr[6] = 1919; fr[30] = 1920;
        send_frame(32, 0, 4, 1'b0);
        check_box("exact", 1, 5, 6, 0, 3, 2, 0);

        // Restart mid-frame: only the second frame reports.
        p0 = n_pulses;
        hue_lo = 20'd1760; hue_hi = 20'd2080;
        fill(1920);
        send_frame(32, 10, 0, 1'b0);
        fill(0); fr[9] = 1900; fr[18] = 2000;
        send_frame(32, 0, 4, 1'b0);
        check_eq("restart_pulses", n_pulses - p0, 1);
        check_box("restart", 1, 1, 2, 1, 2, 2, 0);

        // One-pixel frame.
        beat(1'b1, 1'b1, 1'b1, 1920);
        idle(4);
        check_box("one_pixel", 0, 0, 0, 0, 0, 1, 1);

        // Back-to-back frames with no gap.
        p0 = n_pulses;
        fill(1920);
        send_frame(32, 0, 0, 1'b0);
        hue_lo = 20'd5600; hue_hi = 20'd160;
        fill(0); fr[31] = 2000;
        send_frame(32, 0, 4, 1'b0);
        check_eq("b2b_pulses", n_pulses - p0, 2);

        // Reset mid-frame.
        p0 = n_pulses;
        fill(0);
        send_frame(32, 15, 0, 1'b0);
        rst_n = 1'b0;
        in_frame = 1'b0;
        beat(1'b1, 1'b0, 1'b0, 0);
        check_zero("mid_reset");
        rst_n = 1'b1;
        beat(1'b1, 1'b0, 1'b0, 0);
        beat(1'b1, 1'b0, 1'b1, 0);
        idle(4);
        check_eq("mid_reset_no_report", n_pulses - p0, 0);

        // Randomized frames.
        for (int f = 0; f < 60; f++) begin
            lo_r = $urandom_range(0, HMAX - 1);
            hi_r = ($urandom_range(0, 3) == 0) ? lo_r : $urandom_range(0, HMAX - 1);
            hue_lo = 20'(lo_r); hue_hi = 20'(hi_r);
            for (int i = 0; i < 64; i++) begin
                sel = $urandom_range(0, 5);
                case (sel)
                    0: fr[i] = lo_r;
                    1: fr[i] = hi_r;
                    2: fr[i] = (lo_r + HMAX - 1) % HMAX;
                    3: fr[i] = (hi_r + 1) % HMAX;
                    default: fr[i] = $urandom_range(0, HMAX - 1);
                endcase
            end
            len = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 40) : 32;
            send_frame(len, 0, $urandom_range(0, 2), 1'b1);
        end

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
        check_eq("pending_reports", exp_q.size(), 0);
        check_eq("total_pulses", n_pulses, n_expect);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hue_bbox.md
# hue_bbox

Per-frame colour-blob locator that sits directly downstream of the RGB-to-hue converter in the vision pipeline. It consumes the converter's hue stream, one pixel per valid beat in raster order, and classifies each pixel against a programmable hue window. The window may wrap through 0°. For each frame it reports the bounding box and pixel count of the matching pixels, which the rover navigation logic reads as the target location.

## Interface
Parameters:
- PRECISION, 20: hue word width; must match the upstream converter.
- FIXED, 4: fractional bits of hue; hue = degrees × 2^FIXED, valid range 0 … 360·2^FIXED − 1.
- IMG_W, 640: pixels per line.
- IMG_H, 480: lines per frame.
- MIN_PIXELS, 16: minimum match count for a frame to report `found`.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  hue beat valid. There is no backpressure; every valid beat is consumed.
- in_sop  in  1  first pixel of frame; qualified by in_valid.
- in_eop  in  1  last pixel of frame; qualified by in_valid.
- hue  in  PRECISION  pixel hue, already aligned with in_valid.
- hue_lo  in  PRECISION  window lower bound, inclusive.
- hue_hi  in  PRECISION  window upper bound, inclusive.
- box_valid  out  1  one-cycle pulse; the report outputs below are updated on this cycle.
- found  out  1  pix_count ≥ MIN_PIXELS.
- x_min, x_max  out  clog2(IMG_W)  bounding-box columns.
- y_min, y_max  out  clog2(IMG_H)  bounding-box rows.
- pix_count  out  clog2(IMG_W·IMG_H+1)  matching pixels; saturating.
- frame_err  out  1  the reported frame had a length violation.

## Operation
- States:
  - IDLE: wait for a valid sop.
  - ACTIVE: accumulate pixels.
  - REPORT: one cycle, latches outputs.
- Transitions:
  - IDLE→ACTIVE on in_valid&in_sop.
  - ACTIVE→REPORT on in_valid&in_eop.
  - REPORT→IDLE unconditionally, or REPORT→ACTIVE if a valid sop arrives in the REPORT cycle.
- In IDLE, valid beats without sop are ignored.
- On sop:
  - x and y are set to 0.
  - Accumulators clear: min fields = all-ones, max fields = 0, count = 0, err = 0.
  - hue_lo and hue_hi are latched. Changes to them mid-frame have no effect until the next sop.
  - The sop pixel itself is evaluated as pixel (0,0).
- Position counters:
  - x increments on each valid beat.
  - At x = IMG_W−1, x wraps to 0 and y increments.
- Match rule:
  - If lo ≤ hi: lo ≤ hue ≤ hi.
  - If lo > hi (wrap window, e.g. red): hue ≥ lo OR hue ≤ hi.
  - lo = hi matches exactly one hue code.
- On each match:
  - x_min = min(x_min, x); x_max = max(x_max, x); same for y.
  - count += 1, saturating at all-ones.
- sop while in ACTIVE: the partial frame is discarded and no report is issued. The new frame starts with that pixel.
- Beat with sop and eop together: a 1-pixel frame, processed normally.
- frame_err is set if:
  - eop arrives at a position other than (IMG_W−1, IMG_H−1), or
  - any pixel arrives after position (IMG_W−1, IMG_H−1) without an eop. Counters hold at the last position.
- In REPORT:
  - found = count ≥ MIN_PIXELS.
  - If not found, x/y outputs are driven to 0. pix_count still reports the true count.
- Report outputs hold their values until the next REPORT.

## Timing
- Reset (rst_n low at an edge): state=IDLE. All outputs are 0, including box_valid, found and frame_err. Accumulators are cleared.
- Reset asserted mid-frame aborts the frame with no report.
- Pipeline:
  - Cycle N: beat accepted.
  - N+1: match bit and position registered.
  - N+2: accumulators updated.
- An eop accepted at cycle N gives box_valid high at N+2 for exactly one cycle.
- Back-to-back frames (sop at N+1 after eop at N) are fully supported. The new frame's clear must not corrupt the pending report; the report is taken from the old accumulators.
- Throughput: one pixel per clock, sustained.

## Structure
- Shared header vision_defs.vh holds:
  - hue scaling constants: HUE_FIXED, and HUE_360 = 360·2^FIXED.
  - the state encoding localparams.
  - the default image dimensions.
- Sub-module hue_window_match: a combinational compare of hue against lo/hi, including the wrap rule, producing a 1-bit match. It is reused later by the multi-colour classifier.
- The top-level hue_bbox contains the FSM, the position counters, the match register, the accumulators and the report registers.

## Test plan
All scenarios use IMG_W=8, IMG_H=4, FIXED=4, MIN_PIXELS=2.

- Basic box: lo=1760, hi=2080 (110°–130°); hue=1920 at (2,1), (5,1), (3,3); all other pixels hue=0.
  - Expect: box_valid 2 cycles after eop; found=1; x 2..5; y 1..3; count=3; frame_err=0.
- Wrap window: lo=5600 (350°), hi=160 (10°). Pixels hue=5700 at (0,0) and hue=100 at (7,3); hue=2000 elsewhere.
  - Expect: box x 0..7, y 0..3, count=2.
- Below threshold: single match at (4,2).
  - Expect: found=0, x/y outputs 0, count=1.
- Early eop at pixel index 20: expect report with frame_err=1.
- Restart and back-to-back frames:
  - A second sop mid-frame: no report for the aborted frame; the next full frame reports correctly.
  - Back-to-back frames with no gap: two box_valid pulses, each with correct values.
- Reset and idle behaviour:
  - rst_n low mid-frame: outputs 0, no box_valid.
  - Valid beats without sop after reset: ignored.
